// File: rtl/instr_encode_loader.sv
// ---------------------------------------------------------------------------
// instr_encode_loader
//   Packs field-level instruction requests into 32-bit core ISA words and
//   writes them to instruction memory at consecutive addresses starting from
//   a base latched on start. Encoded words wait in a small FIFO in front of a
//   single-entry write port register.
//
// Ports
//   clk, rst           clock (rising edge) / synchronous active-low reset
//   start, base_addr   begin a session (IDLE only), latch first address
//   in_valid/in_ready  request handshake; in_last marks the final request
//   in_class .. in_imm instruction fields to encode
//   mem_we/addr/wdata  write request, held stable until mem_ack
//   mem_ack            write complete (ignored while mem_we is low)
//   busy, done         state != IDLE / one-cycle end-of-session pulse
//   word_count         words written this session
//   wrap_err           sticky: address counter wrapped past all-ones
// ---------------------------------------------------------------------------
// state  | meaning
// IDLE   | waiting for start
// RUN    | accepting requests, writing as words become available
// DRAIN  | last request taken, flushing FIFO and pending write
// DONE   | single cycle, done asserted
// ---------------------------------------------------------------------------
module instr_encode_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        in_class,
  input  logic              in_special,
  input  logic              in_set_flags,
  input  logic [2:0]        in_alu_op,
  input  logic [3:0]        in_dest,
  input  logic [3:0]        in_src1,
  input  logic [3:0]        in_src2,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              wrap_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   wc_q;
  logic              wrap_q;

  logic              fifo_full, fifo_empty;
  logic              push, ack, load;
  logic [16:0]       enc_low;
  logic [31:0]       enc_word;

  assign fifo_full  = (cnt_q == CNT_W'(DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // Full comes from the registered count, so a same-cycle pop never frees a slot.
  assign in_ready = (state_q == ST_RUN) && !fifo_full;
  assign push     = in_valid && in_ready;
  assign ack      = mem_ack && we_q;
  // The head moves into the write register either when the port is idle or
  // on the ack edge of the current write, giving one word per cycle.
  assign load     = !fifo_empty && (!we_q || ack);

  // Register-form words carry src2 and zero padding; all others carry imm.
  assign enc_low  = (in_class == 2'b01) ? {in_src2, 13'b0} : {1'b0, in_imm};
  assign enc_word = {in_class, in_special, in_set_flags, in_alu_op,
                     in_dest, in_src1, enc_low};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (push && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !we_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wc_q     <= '0;
      wrap_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (load) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      if (push && !load)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!push && load) cnt_q <= cnt_q - CNT_W'(1);

      if (load) begin
        we_q    <= 1'b1;
        wdata_q <= fifo_q[rd_ptr_q];
      end else if (ack) begin
        we_q    <= 1'b0;
      end

      if (state_q == ST_IDLE && start) begin
        addr_q <= base_addr;
        wc_q   <= '0;
        wrap_q <= 1'b0;
      end else if (ack) begin
        addr_q <= addr_q + ADDR_W'(1);
        wc_q   <= wc_q + (ADDR_W+1)'(1);
        if (&addr_q) wrap_q <= 1'b1;
      end
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign word_count = wc_q;
  assign wrap_err   = wrap_q;

endmodule
